// File: rtl/dice_pkg.sv
// dice_pkg -- shared types and constants for the dice roller.
//   face_t   : 3-bit die face, legal values FACE_MIN..FACE_MAX
//   state_t  : roller sequencing states
//   FACE_SUM : opposite faces of a die always add up to this value
package dice_pkg;

  typedef logic [2:0] face_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2
  } state_t;

  localparam face_t FACE_MIN = 3'd1;
  localparam face_t FACE_MAX = 3'd6;
  localparam face_t FACE_SUM = 3'd7;

endpackage

// File: rtl/dice_step.sv
// dice_step -- combinational next-face function for one die.
// The candidates are the four faces other than v and its opposite
// (FACE_SUM - v), taken in ascending order; sel picks one of them.
// Ports:
//   v         in   current face
//   sel       in   2-bit random selector
//   next_face out  face shown after the step
module dice_step
  import dice_pkg::*;
(
  input  face_t       v,
  input  logic [1:0]  sel,
  output face_t       next_face
);

  face_t      opp;
  logic [2:0] idx;

  assign opp = FACE_SUM - v;

  always_comb begin
    next_face = FACE_MIN;
    idx       = 3'd0;
    for (int f = int'(FACE_MIN); f <= int'(FACE_MAX); f++) begin
      if (face_t'(f) != v && face_t'(f) != opp) begin
        if (idx == {1'b0, sel}) next_face = face_t'(f);
        idx = idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/dice_roller.sv
// dice_roller -- electronic dice with a fast roll phase and a slowing
// settle phase.
//
//   state | meaning
//   IDLE  | dice hold; Valid reports a completed roll
//   ROLL  | button held, dice step every 2 cycles
//   SLOW  | button released, step period doubles 2,4,..,MAX_INTERVAL
//
// Ports:
//   Clock      in   rising-edge clock
//   nReset     in   asynchronous active-low reset
//   Ran        in   2 random bits per die (die i: Ran[2i+1:2i])
//   Roll       in   roll request, level sensitive
//   DiceValue  out  3 bits per die (die i: DiceValue[3i+2:3i])
//   Rolling    out  state is not IDLE
//   Valid      out  dice settled after a completed roll
//   Sum        out  total of all faces (only with DICE_ROLLER_SUM_EN)
//
// Build option: define DICE_ROLLER_SUM_EN to add the Sum output.
module dice_roller
  import dice_pkg::*;
#(
  parameter int NUM_DICE     = 2,
  parameter int MAX_INTERVAL = 64
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [2*NUM_DICE-1:0] Ran,
  input  logic                  Roll,
  output logic [3*NUM_DICE-1:0] DiceValue,
  output logic                  Rolling,
  output logic                  Valid
`ifdef DICE_ROLLER_SUM_EN
  ,
  output logic [4:0]            Sum
`endif
);

  // One extra bit so the interval can hold MAX_INTERVAL itself.
  localparam int CW = $clog2(MAX_INTERVAL) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] interval, interval_nxt;
  logic          valid_nxt;
  logic          step;

  face_t face      [NUM_DICE];
  face_t face_step [NUM_DICE];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      cnt      <= '0;
      interval <= '0;
      Valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      interval <= interval_nxt;
      Valid    <= valid_nxt;
    end
  end

  // A change of Roll takes priority over a step due on the same edge.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    interval_nxt = interval;
    valid_nxt    = Valid;
    step         = 1'b0;
    case (state)
      IDLE: begin
        if (Roll) begin
          state_nxt = ROLL;
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      ROLL: begin
        if (!Roll) begin
          state_nxt    = SLOW;
          cnt_nxt      = '0;
          interval_nxt = CW'(2);
        end else if (cnt == CW'(1)) begin
          step    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SLOW: begin
        if (Roll) begin
          state_nxt = ROLL;
          cnt_nxt   = '0;
        end else if (cnt == interval - CW'(1)) begin
          step    = 1'b1;
          cnt_nxt = '0;
          if (interval == CW'(MAX_INTERVAL)) begin
            state_nxt = IDLE;
            valid_nxt = 1'b1;
          end else begin
            interval_nxt = interval << 1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign Rolling = (state != IDLE);

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
    dice_step u_step (
      .v         (face[i]),
      .sel       (Ran[2*i+1:2*i]),
      .next_face (face_step[i])
    );
    assign DiceValue[3*i+2:3*i] = face[i];
  end

  // Ran only reaches the face registers on step edges.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_DICE; i++) face[i] <= FACE_MIN;
    end else if (step) begin
      for (int i = 0; i < NUM_DICE; i++) face[i] <= face_step[i];
    end
  end

`ifdef DICE_ROLLER_SUM_EN
  always_comb begin
    Sum = 5'd0;
    for (int i = 0; i < NUM_DICE; i++) Sum = Sum + 5'(face[i]);
  end
`endif

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter NUM_DICE, default 2, number of independent dice (legal 1..4).
REQ-002 SHALL have parameter MAX_INTERVAL, default 64, slowest step period in cycles during deceleration (power of two, legal 4..256).
REQ-003 SHALL have port Clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Ran  input  2*NUM_DICE  random bits; die i uses Ran[2i+1:2i].
REQ-006 SHALL have port Roll  input  1  roll request, level (button held = rolling).
REQ-007 SHALL have port DiceValue  output  3*NUM_DICE  die i face (1..6) in DiceValue[3i+2:3i].
REQ-008 SHALL have port Rolling  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port Valid  output  1  high when the dice have settled after a completed roll.

Function
REQ-010 SHALL implement states IDLE, ROLL, SLOW.
REQ-011 IDLE: dice hold. Roll=1 -> ROLL; Valid clears on the same edge.
REQ-012 ROLL: every die steps once per 2 cycles; interval counter cleared on entry; first step on the 2nd edge in ROLL.
REQ-013 ROLL with Roll=0 -> SLOW with interval=2 and counter cleared.
REQ-014 SLOW: each die steps when counter reaches interval-1; the counter then clears and interval doubles.
REQ-015 SLOW: the step taken at interval==MAX_INTERVAL is the last; on that same edge go to IDLE and set Valid=1.
REQ-016 SLOW with Roll=1 -> ROLL with counter cleared; Valid stays 0.
REQ-017 Step rule, per die, current face v: the candidate set is the four faces excluding v and 7-v, in ascending order; Ran pair value 0..3 selects the index.
REQ-018 Ran SHALL be sampled only on step edges; dice SHALL never show the same or the opposite face on consecutive steps.
REQ-019 All dice SHALL step on the same edge.
REQ-020 Valid SHALL stay high in IDLE until the next Roll.
REQ-021 Interval counter width SHALL be clog2(MAX_INTERVAL)+1 bits, with no wrap before MAX_INTERVAL.

Reset
REQ-022 nReset low SHALL asynchronously force state IDLE, every die to 3'd1, Valid=0, Rolling=0, and counter and interval cleared, including mid-ROLL or mid-SLOW.
REQ-023 The first Roll after reset SHALL behave as from IDLE.

Configuration
REQ-024 Macro DICE_ROLLER_SUM_EN defined: add output Sum (5 bits) equal to the combinational sum of all faces, derived from the registered DiceValue with zero latency, reset value NUM_DICE.
REQ-025 Macro undefined: the Sum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package dice_pkg SHALL hold the typedef face_t (3 bits), the state enum, and constants FACE_MIN=1, FACE_MAX=6 and FACE_SUM=7.
REQ-027 Sub-module dice_step SHALL be the combinational next-face function of (face_t v, 2-bit sel), instantiated NUM_DICE times.

Verification
REQ-028 Reset -> DiceValue all 3'd1, Valid=0, Rolling=0; assert nReset mid-SLOW -> same values immediately.
REQ-029 NUM_DICE=2, Ran=0, Roll held 20 cycles -> each die alternates 1,2,1,2 every 2 cycles (10 steps); Rolling=1 throughout.
REQ-030 MAX_INTERVAL=8, Roll released -> 3 further steps, 2/4/8 cycles apart; Valid=1 and Rolling=0 on the 14th cycle after entering SLOW.
REQ-031 Roll re-asserted on the 2nd step of SLOW -> back to ROLL, stepping every 2 cycles, Valid stays 0.
REQ-032 Random Ran and Roll over 10k steps -> every face in 1..6, never equal to or opposite the previous face, all dice step together.
REQ-033 DICE_ROLLER_SUM_EN, NUM_DICE=4 -> Sum=4 after reset; Sum equals the face total every cycle.
